fragment_writer: RTL and testbench
==================================

// Module: fragment_writer
// PURPOSE
//  Consumes the rasterizer's fragment stream (valid/x/y, one per cycle, no backpressure) and writes each
//  fragment's colour into a linear framebuffer memory via a req/ready write port. A FIFO absorbs memory
//  stalls, off-screen fragments are clipped, and o_idle tells the triangle sequencer when a triangle is
//  fully committed to memory.
// PARAMETERS
//  CORD_WIDTH   10   fragment coordinate width (matches rasterizer)
//  COLOR_WIDTH  16   colour/data width written per pixel
//  FB_WIDTH     640  framebuffer width in pixels (row pitch)
//  FB_HEIGHT    480  framebuffer height in pixels
//  ADDR_WIDTH   19   memory word address width; must hold FB_WIDTH*FB_HEIGHT-1
//  FIFO_DEPTH   8    write FIFO entries, power of two, >=2
//  CNT_WIDTH    16   width of status counters
// PORTS
//  clk            in   1                  clock, all logic rising-edge
//  rst            in   1                  reset, asynchronous, active-high
//  i_frag_valid   in   1                  fragment present this cycle
//  i_frag_x       in   CORD_WIDTH         fragment x (unsigned)
//  i_frag_y       in   CORD_WIDTH         fragment y (unsigned)
//  i_frag_color   in   COLOR_WIDTH        colour for this fragment
//  i_raster_done  in   1                  rasterizer done/idle level
//  i_clear_status in   1                  one-cycle pulse: clear o_overflow and counters
//  o_mem_req      out  1                  write request valid
//  o_mem_addr     out  ADDR_WIDTH         word address = y*FB_WIDTH + x
//  o_mem_data     out  COLOR_WIDTH        write data
//  i_mem_ready    in   1                  memory accepts write when high with o_mem_req
//  o_fifo_level   out  $clog2(FIFO_DEPTH)+1  entries currently in FIFO
//  o_overflow     out  1                  sticky: a fragment was lost to a full FIFO
//  o_clip_count   out  CNT_WIDTH          fragments discarded as off-screen (saturating)
//  o_write_count  out  CNT_WIDTH          writes accepted by memory (saturating)
//  o_idle         out  1                  i_raster_done && stage empty && FIFO empty
// BEHAVIOUR
//  - Reset (async, immediate): stage reg empty, FIFO empty; o_mem_req=0, o_mem_addr=0, o_mem_data=0,
//    o_fifo_level=0, o_overflow=0, counters=0; o_idle follows i_raster_done.
//  - Stage 1 (edge N): if i_frag_valid, compare x<FB_WIDTH && y<FB_HEIGHT. In range: register
//    addr=y*FB_WIDTH+x (unsigned, computed at ADDR_WIDTH, no truncation given param rule) and colour,
//    stage valid=1. Out of range: stage valid=0, o_clip_count+1 (saturate at all-ones).
//  - Stage 2 (edge N+1): valid stage entry pushes into FIFO. Latency: fragment in cycle N with empty
//    FIFO -> o_mem_req high in cycle N+2.
//  - FIFO is first-word-fall-through: o_mem_req = !empty; o_mem_addr/o_mem_data = head entry, held
//    stable while o_mem_req && !i_mem_ready. Pop when o_mem_req && i_mem_ready at a rising edge;
//    o_write_count+1 (saturating). Order strictly preserved. o_mem_addr/data = 0 when empty.
//  - Full: push with FIFO full and no simultaneous pop -> entry dropped, o_overflow<=1, level unchanged.
//    Push and pop on same edge while full -> both occur, no overflow, level unchanged.
//  - o_fifo_level updates on the edge of the push/pop (+1, -1, or 0 if both).
//  - i_clear_status: clears o_overflow, o_clip_count, o_write_count at that edge; an increment on the
//    same edge is lost (clear wins). FIFO contents unaffected.
//  - o_idle combinational; deasserted while any fragment is in stage 1 or FIFO even if
//    i_raster_done=1.
//  - No state machine beyond pipeline valid + FIFO pointers; pointers wrap modulo FIFO_DEPTH with an
//    extra MSB to distinguish full/empty.
//  - Reset mid-operation: all queued writes discarded; no write issued after reset deasserts until a
//    new fragment arrives.
// TESTING
//  1. Fragment x=3,y=2,color=16'hF800, ready=1 -> o_mem_req high exactly 2 cycles later for 1 cycle,
//     addr=1283, data=16'hF800, write_count=1.
//  2. ready=0, 10 in-range fragments back-to-back -> level=8, overflow=1 after the 9th; ready=1 ->
//     first 8 written in order; write_count=8.
//  3. Fragments (640,0),(0,480),(639,479) -> one write addr=307199; clip_count=2.
//  4. FIFO full, ready=1 and a new fragment every cycle for 20 cycles -> overflow stays 0, level
//     stays 8.
//  5. 5 entries queued, assert rst mid-stall -> o_mem_req=0 same cycle, level=0, counters=0; after
//     release with ready=1 no writes.
//  6. raster_done=1 with 3 queued, ready=1 -> o_idle=0 until cycle after 3rd accept, then 1;
//     i_clear_status pulse -> counters 0.

Source files
------------

// File: rtl/fragment_writer.sv
// fragment_writer
//   Takes the rasterizer fragment stream (one per cycle, no backpressure),
//   clips off-screen fragments, turns (x,y) into a linear framebuffer word
//   address and queues colour writes in a first-word-fall-through FIFO that
//   drains through a req/ready memory write port.
// Ports
//   clk, rst             clock (rising edge), async active-high reset
//   i_frag_*             fragment valid / x / y / colour
//   i_raster_done        rasterizer has finished the current triangle
//   i_clear_status       pulse: clear overflow flag and counters
//   o_mem_req/addr/data  write request (head of FIFO), i_mem_ready accepts
//   o_fifo_level         entries held in the FIFO
//   o_overflow           sticky: a fragment was dropped on a full FIFO
//   o_clip_count         saturating count of off-screen fragments
//   o_write_count        saturating count of accepted writes
//   o_idle               raster done and nothing left in flight
module fragment_writer #(
  parameter int CORD_WIDTH  = 10,
  parameter int COLOR_WIDTH = 16,
  parameter int FB_WIDTH    = 640,
  parameter int FB_HEIGHT   = 480,
  parameter int ADDR_WIDTH  = 19,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_frag_valid,
  input  logic [CORD_WIDTH-1:0]        i_frag_x,
  input  logic [CORD_WIDTH-1:0]        i_frag_y,
  input  logic [COLOR_WIDTH-1:0]       i_frag_color,
  input  logic                         i_raster_done,
  input  logic                         i_clear_status,
  output logic                         o_mem_req,
  output logic [ADDR_WIDTH-1:0]        o_mem_addr,
  output logic [COLOR_WIDTH-1:0]       o_mem_data,
  input  logic                         i_mem_ready,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level,
  output logic                         o_overflow,
  output logic [CNT_WIDTH-1:0]         o_clip_count,
  output logic [CNT_WIDTH-1:0]         o_write_count,
  output logic                         o_idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + COLOR_WIDTH;
  // One extra bit so the bounds compare never truncates FB_WIDTH/FB_HEIGHT.
  localparam logic [CORD_WIDTH:0] FBW = (CORD_WIDTH+1)'(FB_WIDTH);
  localparam logic [CORD_WIDTH:0] FBH = (CORD_WIDTH+1)'(FB_HEIGHT);

  // ---------------- stage 1: clip + address ----------------
  logic                   in_range;
  logic [ADDR_WIDTH-1:0]  addr_calc;
  logic                   stg_vld_q;
  logic [ADDR_WIDTH-1:0]  stg_addr_q;
  logic [COLOR_WIDTH-1:0] stg_col_q;

  assign in_range  = ({1'b0, i_frag_x} < FBW) && ({1'b0, i_frag_y} < FBH);
  assign addr_calc = ADDR_WIDTH'(i_frag_y) * ADDR_WIDTH'(FB_WIDTH) + ADDR_WIDTH'(i_frag_x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld_q  <= 1'b0;
      stg_addr_q <= '0;
      stg_col_q  <= '0;
    end else begin
      stg_vld_q <= i_frag_valid && in_range;
      if (i_frag_valid && in_range) begin
        stg_addr_q <= addr_calc;
        stg_col_q  <= i_frag_color;
      end
    end
  end

  // ---------------- stage 2: FWFT FIFO ----------------
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty, full, pop, push_ok, drop;
  logic [EW-1:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop   = !empty && i_mem_ready;
  // A simultaneous pop frees the slot being written, so a full FIFO still
  // accepts the push in that case.
  assign push_ok = stg_vld_q && (!full || pop);
  assign drop    = stg_vld_q && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[PW-1:0]] <= {stg_addr_q, stg_col_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign head         = fifo_mem[rd_ptr_q[PW-1:0]];
  assign o_mem_req    = !empty;
  assign o_mem_addr   = empty ? '0 : head[EW-1:COLOR_WIDTH];
  assign o_mem_data   = empty ? '0 : head[COLOR_WIDTH-1:0];
  assign o_fifo_level = wr_ptr_q - rd_ptr_q;

  // ---------------- status ----------------
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] clip_q, clip_d, wcnt_q, wcnt_d;

  always_comb begin
    ovf_d  = ovf_q | drop;
    clip_d = clip_q;
    wcnt_d = wcnt_q;
    if (i_frag_valid && !in_range && clip_q != '1) clip_d = clip_q + 1'b1;
    if (pop && wcnt_q != '1)                       wcnt_d = wcnt_q + 1'b1;
    // Clear wins over any same-edge increment.
    if (i_clear_status) begin
      ovf_d  = 1'b0;
      clip_d = '0;
      wcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      clip_q <= '0;
      wcnt_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      clip_q <= clip_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign o_overflow    = ovf_q;
  assign o_clip_count  = clip_q;
  assign o_write_count = wcnt_q;
  assign o_idle        = i_raster_done && !stg_vld_q && empty;

endmodule

// File: tb/tb_fragment_writer.sv
module tb_fragment_writer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fv = 1'b0;
  logic [9:0]  fx = '0, fy = '0;
  logic [15:0] fcol = '0;
  logic        rdone = 1'b0;
  logic        clr = 1'b0;
  logic        rdy = 1'b0;
  logic        o_mem_req;
  logic [18:0] o_mem_addr;
  logic [15:0] o_mem_data;
  logic [3:0]  o_fifo_level;
  logic        o_overflow;
  logic [15:0] o_clip_count, o_write_count;
  logic        o_idle;

  int nvec = 0;
  int nerr = 0;

  fragment_writer dut (
    .clk(clk), .rst(rst),
    .i_frag_valid(fv), .i_frag_x(fx), .i_frag_y(fy), .i_frag_color(fcol),
    .i_raster_done(rdone), .i_clear_status(clr),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_ready(rdy), .o_fifo_level(o_fifo_level), .o_overflow(o_overflow),
    .o_clip_count(o_clip_count), .o_write_count(o_write_count), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending {addr,colour} writes plus a one-deep
  // staging slot, advanced once per clock edge from the specified rules.
  logic [34:0] mq[$];
  bit          m_sv;
  logic [34:0] m_stg;
  logic [15:0] m_clip, m_wc;
  bit          m_ovf;

  task automatic model_clear();
    mq.delete();
    m_sv = 0; m_stg = '0; m_clip = '0; m_wc = '0; m_ovf = 0;
  endtask

  task automatic tick();
    bit pop;
    int a;
    @(posedge clk);
    if (rst) model_clear();
    else begin
      pop = (mq.size() != 0) && rdy;
      if (pop) begin
        void'(mq.pop_front());
        if (m_wc != 16'hFFFF) m_wc++;
      end
      if (m_sv) begin
        if (mq.size() == DEPTH) m_ovf = 1;
        else mq.push_back(m_stg);
      end
      m_sv = 0;
      if (fv) begin
        if (fx < 640 && fy < 480) begin
          a = int'(fy) * 640 + int'(fx);
          m_sv = 1;
          m_stg = {a[18:0], fcol};
        end else if (m_clip != 16'hFFFF) m_clip++;
      end
      if (clr) begin m_clip = '0; m_wc = '0; m_ovf = 0; end
    end
    #1;
  endtask

  task automatic test_reset();
    #3;
    nvec++; if (o_mem_req !== 1'b0) begin nerr++; $display("FAIL rst_req got %b exp 0", o_mem_req); end
    nvec++; if (o_mem_addr !== 19'd0 || o_mem_data !== 16'd0) begin nerr++; $display("FAIL rst_addr_data got %0d/%h exp 0/0", o_mem_addr, o_mem_data); end
    nvec++; if (o_fifo_level !== 4'd0 || o_overflow !== 1'b0) begin nerr++; $display("FAIL rst_lvl_ovf got %0d/%b exp 0/0", o_fifo_level, o_overflow); end
    nvec++; if (o_clip_count !== 16'd0 || o_write_count !== 16'd0) begin nerr++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", o_clip_count, o_write_count); end
    nvec++; if (o_idle !== 1'b0) begin nerr++; $display("FAIL rst_idle0 got %b exp 0", o_idle); end
    rdone = 1'b1; #1;
    nvec++; if (o_idle !== 1'b1) begin nerr++; $display("FAIL rst_idle1 got %b exp 1", o_idle); end
    rdone = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    rdy = 1; fv = 1; fx = 3; fy = 2; fcol = 16'hF800;
    tick();
    fv = 0;
    nvec++; if (o_mem_req !== 1'b0) begin nerr++; $display("FAIL single_early got %b exp 0", o_mem_req); end
    tick();
    nvec++; if (o_mem_req !== 1'b1) begin nerr++; $display("FAIL single_req got %b exp 1", o_mem_req); end
    nvec++; if (o_mem_addr !== 19'd1283 || o_mem_data !== 16'hF800) begin nerr++; $display("FAIL single_addr got %0d/%h exp 1283/f800", o_mem_addr, o_mem_data); end
    tick();
    nvec++; if (o_mem_req !== 1'b0) begin nerr++; $display("FAIL single_one_cycle got %b exp 0", o_mem_req); end
    nvec++; if (o_write_count !== 16'd1) begin nerr++; $display("FAIL single_wc got %0d exp 1", o_write_count); end
  endtask

  task automatic test_overflow();
    logic [15:0] cols[10];
    clr = 1; tick(); clr = 0;
    rdy = 0;
    for (int i = 0; i < 10; i++) begin
      fv = 1; fx = 10'(i); fy = 0; fcol = 16'($urandom); cols[i] = fcol;
      tick();
      nvec++; if (o_overflow !== (i >= 9)) begin nerr++; $display("FAIL ovf_step%0d got %b exp %b", i, o_overflow, (i >= 9)); end
    end
    fv = 0;
    tick();
    nvec++; if (o_fifo_level !== 4'd8 || o_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_full got %0d/%b exp 8/1", o_fifo_level, o_overflow); end
    rdy = 1;
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 19'(i) || o_mem_data !== cols[i]) begin
        nerr++; $display("FAIL ovf_order%0d got %b/%0d/%h exp 1/%0d/%h", i, o_mem_req, o_mem_addr, o_mem_data, i, cols[i]);
      end
      tick();
    end
    nvec++; if (o_mem_req !== 1'b0 || o_write_count !== 16'd8) begin nerr++; $display("FAIL ovf_drain got %b/%0d exp 0/8", o_mem_req, o_write_count); end
  endtask

  task automatic test_clip();
    int writes = 0;
    logic [18:0] last = '0;
    clr = 1; tick(); clr = 0;
    rdy = 1;
    fv = 1; fx = 640; fy = 0;   fcol = 16'h1111; tick();
    fx = 0;   fy = 480; fcol = 16'h2222; tick();
    fx = 639; fy = 479; fcol = 16'h3333; tick();
    fv = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_mem_req) begin writes++; last = o_mem_addr; end
      tick();
    end
    nvec++; if (writes != 1 || last !== 19'd307199) begin nerr++; $display("FAIL clip_write got %0d@%0d exp 1@307199", writes, last); end
    nvec++; if (o_clip_count !== 16'd2 || o_write_count !== 16'd1) begin nerr++; $display("FAIL clip_cnt got %0d/%0d exp 2/1", o_clip_count, o_write_count); end
  endtask

  task automatic test_full_stream();
    clr = 1; tick(); clr = 0;
    for (int i = 0; i < 29; i++) begin
      fv = 1; fx = 10'(i); fy = 10'd5; fcol = 16'($urandom);
      rdy = (i >= 9);
      tick();
      if (i >= 9) begin
        nvec++; if (o_fifo_level !== 4'd8 || o_overflow !== 1'b0) begin nerr++; $display("FAIL stream%0d got %0d/%b exp 8/0", i, o_fifo_level, o_overflow); end
      end
    end
    fv = 0; rdy = 1;
    for (int i = 0; i < 12; i++) tick();
    nvec++; if (o_fifo_level !== 4'd0) begin nerr++; $display("FAIL stream_drain got %0d exp 0", o_fifo_level); end
  endtask

  task automatic test_rst_mid();
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      fv = 1; fx = 10'(100 + i); fy = 10'd7; fcol = 16'($urandom); tick();
    end
    fv = 0; tick(); tick();
    nvec++; if (o_fifo_level !== 4'd5) begin nerr++; $display("FAIL rmid_lvl got %0d exp 5", o_fifo_level); end
    #2 rst = 1; model_clear();
    #1;
    nvec++; if (o_mem_req !== 1'b0 || o_fifo_level !== 4'd0) begin nerr++; $display("FAIL rmid_async got %b/%0d exp 0/0", o_mem_req, o_fifo_level); end
    nvec++; if (o_clip_count !== 16'd0 || o_write_count !== 16'd0 || o_overflow !== 1'b0) begin nerr++; $display("FAIL rmid_cnt got %0d/%0d/%b exp 0/0/0", o_clip_count, o_write_count, o_overflow); end
    tick();
    rst = 0; rdy = 1;
    for (int i = 0; i < 10; i++) begin
      nvec++; if (o_mem_req !== 1'b0) begin nerr++; $display("FAIL rmid_nowrite%0d got %b exp 0", i, o_mem_req); end
      tick();
    end
  endtask

  task automatic test_idle();
    clr = 1; tick(); clr = 0;
    rdone = 1; rdy = 0;
    for (int i = 0; i < 3; i++) begin
      fv = 1; fx = 10'(i); fy = 10'd9; fcol = 16'($urandom); tick();
      nvec++; if (o_idle !== 1'b0) begin nerr++; $display("FAIL idle_fill%0d got %b exp 0", i, o_idle); end
    end
    fv = 0; tick();
    nvec++; if (o_idle !== 1'b0 || o_fifo_level !== 4'd3) begin nerr++; $display("FAIL idle_queued got %b/%0d exp 0/3", o_idle, o_fifo_level); end
    rdy = 1;
    for (int k = 0; k < 3; k++) begin
      nvec++; if (o_idle !== 1'b0) begin nerr++; $display("FAIL idle_busy%0d got %b exp 0", k, o_idle); end
      tick();
    end
    nvec++; if (o_idle !== 1'b1 || o_write_count !== 16'd3) begin nerr++; $display("FAIL idle_done got %b/%0d exp 1/3", o_idle, o_write_count); end
    clr = 1; tick(); clr = 0;
    nvec++; if (o_write_count !== 16'd0 || o_clip_count !== 16'd0 || o_overflow !== 1'b0) begin nerr++; $display("FAIL idle_clear got %0d/%0d/%b exp 0/0/0", o_write_count, o_clip_count, o_overflow); end
  endtask

  task automatic test_random();
    logic [18:0] ea;
    logic [15:0] ed;
    for (int c = 0; c < 600; c++) begin
      fv    = ($urandom_range(0, 99) < 75);
      fx    = 10'($urandom_range(0, 700));
      fy    = 10'($urandom_range(0, 520));
      fcol  = 16'($urandom);
      rdy   = ($urandom_range(0, 99) < (((c / 60) % 2 == 0) ? 25 : 85));
      clr   = ($urandom_range(0, 99) < 3);
      rdone = ($urandom_range(0, 3) != 0);
      tick();
      ea = (mq.size() != 0) ? mq[0][34:16] : '0;
      ed = (mq.size() != 0) ? mq[0][15:0] : '0;
      nvec++; if (o_mem_req !== (mq.size() != 0)) begin nerr++; $display("FAIL rnd_req c%0d got %b exp %b", c, o_mem_req, (mq.size() != 0)); end
      nvec++; if (o_mem_addr !== ea || o_mem_data !== ed) begin nerr++; $display("FAIL rnd_head c%0d got %0d/%h exp %0d/%h", c, o_mem_addr, o_mem_data, ea, ed); end
      nvec++; if (o_fifo_level !== 4'(mq.size())) begin nerr++; $display("FAIL rnd_lvl c%0d got %0d exp %0d", c, o_fifo_level, mq.size()); end
      nvec++; if (o_overflow !== m_ovf) begin nerr++; $display("FAIL rnd_ovf c%0d got %b exp %b", c, o_overflow, m_ovf); end
      nvec++; if (o_clip_count !== m_clip || o_write_count !== m_wc) begin nerr++; $display("FAIL rnd_cnt c%0d got %0d/%0d exp %0d/%0d", c, o_clip_count, o_write_count, m_clip, m_wc); end
      nvec++; if (o_idle !== (rdone && !m_sv && mq.size() == 0)) begin nerr++; $display("FAIL rnd_idle c%0d got %b exp %b", c, o_idle, (rdone && !m_sv && mq.size() == 0)); end
    end
    fv = 0; clr = 0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_overflow();
    test_clip();
    test_full_stream();
    test_rst_mid();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
